mc_ctrl_fsm: RTL

//  Multicycle control unit for the MIPS core; sits directly downstream of IR and consumes its op/funct fields.

---
 rtl/mc_ctrl_fsm.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath enable from state plus IR op/funct.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       irwr,
    output logic       pcwr,
    output logic [1:0] npc_sel,
    output logic       regwr,
    output logic [1:0] a3_sel,
    output logic [1:0] wd_sel,
    output logic       alusrc,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       dmwr,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_EXEC   = 4'd6,
        S_AWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t state, state_nx;

    logic r_type;
    logic is_lw, is_sw, is_ori, is_lui, is_beq, is_j, is_jal, is_jr;
    logic is_addu, is_subu, is_slt, is_ralu;

    assign r_type  = (op == 6'b000000);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_addu = r_type && (funct == 6'b100001);
    assign is_subu = r_type && (funct == 6'b100011);
    assign is_slt  = r_type && (funct == 6'b101010);
    assign is_jr   = r_type && (funct == 6'b001000);
    assign is_ralu = is_addu || is_subu || is_slt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    assign state_o = state;

    // ALU controls shared by EXEC and AWB so the result stays valid for writeback
    logic       ex_alusrc;
    logic [1:0] ex_ext;
    logic [2:0] ex_alu;

    always_comb begin
        ex_alusrc = 1'b0;
        ex_ext    = 2'b00;
        ex_alu    = 3'b000;
        unique case (1'b1)
            is_addu: ex_alu = 3'b000;
            is_subu: ex_alu = 3'b001;
            is_slt:  ex_alu = 3'b011;
            is_ori: begin
                ex_alusrc = 1'b1;
                ex_ext    = 2'b00;
                ex_alu    = 3'b010;
            end
            is_lui: begin
                ex_alusrc = 1'b1;
                ex_ext    = 2'b10;
                ex_alu    = 3'b010;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx   = S_FETCH;
        irwr       = 1'b0;
        pcwr       = 1'b0;
        npc_sel    = 2'b00;
        regwr      = 1'b0;
        a3_sel     = 2'b00;
        wd_sel     = 2'b00;
        alusrc     = 1'b0;
        ext_op     = 2'b00;
        alu_op     = 3'b000;
        dmwr       = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                irwr     = 1'b1;
                pcwr     = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_lw, is_sw:            state_nx = S_MADDR;
                    is_ralu, is_ori, is_lui: state_nx = S_EXEC;
                    is_beq:                  state_nx = S_BRANCH;
                    is_j, is_jal, is_jr:     state_nx = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_nx   = S_FETCH;
                    end
                endcase
            end
            S_MADDR: begin
                alusrc = 1'b1;
                ext_op = 2'b01;
                if (is_lw)      state_nx = S_MREAD;
                else if (is_sw) state_nx = S_MWRITE;
            end
            S_MREAD: begin
                alusrc   = 1'b1;
                ext_op   = 2'b01;
                state_nx = S_MWB;
            end
            S_MWB: begin
                regwr  = 1'b1;
                wd_sel = 2'b01;
            end
            S_MWRITE: begin
                dmwr   = 1'b1;
                alusrc = 1'b1;
                ext_op = 2'b01;
            end
            S_EXEC: begin
                alusrc   = ex_alusrc;
                ext_op   = ex_ext;
                alu_op   = ex_alu;
                state_nx = S_AWB;
            end
            S_AWB: begin
                alusrc = ex_alusrc;
                ext_op = ex_ext;
                alu_op = ex_alu;
                regwr  = 1'b1;
                a3_sel = is_ralu ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alu_op  = 3'b001;
                npc_sel = 2'b01;
                pcwr    = zero;
            end
            S_JUMP: begin
                pcwr    = 1'b1;
                npc_sel = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    regwr  = 1'b1;
                    a3_sel = 2'b10;
                    wd_sel = 2'b10;
                end
            end
            default: begin
                irwr     = 1'b0;
                state_nx = S_FETCH;
            end
        endcase
        // reset wins over any decode so no write leaks past the reset edge
        if (rst) begin
            irwr       = 1'b0;
            pcwr       = 1'b0;
            npc_sel    = 2'b00;
            regwr      = 1'b0;
            a3_sel     = 2'b00;
            wd_sel     = 2'b00;
            alusrc     = 1'b0;
            ext_op     = 2'b00;
            alu_op     = 3'b000;
            dmwr       = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
